readout_arbiter: RTL and testbench

- Sequential arbiter that merges N first-word-fall-through source FIFOs (TLU plus FE-I4 receivers) into the single 32-bit write port of the SRAM out FIFO.
- Grants one source at a time and locks the grant for a bounded burst.
- Rotates round-robin between sources; the TLU source (index 0) can preempt through a priority request.
- Replaces the combinational arbiter between the receiver/TLU FIFOs and out_fifo.

---
 rtl/readout_arbiter.sv | 124 ++++++++++++
 tb/tb_readout_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_arbiter.sv
// Burst-locked round-robin arbiter that merges N FWFT source FIFOs into one
// write port. The TLU source (index 0) can preempt through PREEMPT_REQ.
module readout_arbiter #(
  parameter int N         = 5,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic            BUS_CLK,
  input  logic            BUS_RST_B,
  input  logic [N-1:0]    SRC_EMPTY,
  input  logic [N*DW-1:0] SRC_DATA,
  output logic [N-1:0]    SRC_READ,
  input  logic [N-1:0]    SRC_ENABLE,
  input  logic            PREEMPT_REQ,
  input  logic            OUT_READ,
  output logic            OUT_EMPTY,
  output logic [DW-1:0]   OUT_DATA,
  output logic [N-1:0]    GRANT,
  output logic            READ_ERR
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t          state_q;
  logic [N-1:0]    grant_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   rr_q;
  logic            read_err_q;

  logic [N-1:0]    eligible;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            granted;
  logic            head_empty;
  logic [DW-1:0]   head_data;
  logic            head_enable;
  logic            accept;
  logic            release_d;
  logic            read_err_d;

  assign eligible = SRC_ENABLE & ~SRC_EMPTY;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && eligible[(int'(rr_q) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((int'(rr_q) + k) % N);
      end
    end
    if (PREEMPT_REQ && eligible[0]) begin
      pick_found = 1'b1;
      pick_idx   = '0;
    end
  end

  // grant_q is one-hot (or zero), so an AND-OR mux selects the head word.
  always_comb begin
    head_data   = '0;
    head_empty  = 1'b1;
    head_enable = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        head_data   = SRC_DATA[i*DW +: DW];
        head_empty  = SRC_EMPTY[i];
        head_enable = SRC_ENABLE[i];
      end
    end
  end

  assign granted    = (state_q == GRANTED);
  assign accept     = granted & OUT_READ & ~head_empty;
  assign release_d  = (accept && (cnt_q == CW'(MAX_BURST - 1))) || head_empty ||
                      !head_enable || (PREEMPT_REQ && !grant_q[0]);
  assign read_err_d = OUT_READ & OUT_EMPTY;

  assign OUT_EMPTY = ~granted | head_empty;
  assign OUT_DATA  = granted ? head_data : '0;
  assign SRC_READ  = grant_q & {N{accept}};
  assign GRANT     = grant_q;
  assign READ_ERR  = read_err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      cnt_q      <= '0;
      rr_q       <= IW'(N - 1);
      read_err_q <= 1'b0;
    end else begin
      read_err_q <= read_err_d;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANTED;
            grant_q <= N'(1) << pick_idx;
            rr_q    <= pick_idx;
            cnt_q   <= '0;
          end
        end
        GRANTED: begin
          if (accept) cnt_q <= cnt_q + CW'(1);
          if (release_d) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_arbiter.sv
// Self-checking bench for readout_arbiter: queue-backed source FIFOs, a
// per-cycle reference model of the arbitration rules, and directed scenarios.
module tb_readout_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    src_empty, src_read, src_enable, grant;
  logic [N*DW-1:0] src_data;
  logic            preempt, out_read, out_empty, read_err;
  logic [DW-1:0]   out_data;
  logic            rd_en, force_rd;

  readout_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
    .BUS_CLK(clk), .BUS_RST_B(rst_n), .SRC_EMPTY(src_empty), .SRC_DATA(src_data),
    .SRC_READ(src_read), .SRC_ENABLE(src_enable), .PREEMPT_REQ(preempt),
    .OUT_READ(out_read), .OUT_EMPTY(out_empty), .OUT_DATA(out_data),
    .GRANT(grant), .READ_ERR(read_err)
  );

  // out_fifo model: reads whenever a word is offered; force_rd injects a bad read.
  assign out_read = force_rd | (rd_en & ~out_empty);

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] srcq [N][$];
  logic [DW-1:0] got[$];
  int            bsrc[$], blen[$];
  int            es[$], el[$];
  int            err_seen = 0;

  int m_g = -1, m_cnt = 0, m_rr = N - 1;
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] word(input int s, input int idx);
    return DW'((s << 24) | idx);
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      src_empty[i] = (srcq[i].size() == 0);
      src_data[i*DW +: DW] = src_empty[i] ? '0 : srcq[i][0];
    end
  endtask

  task automatic push(input int s, input int n, input int base);
    for (int k = 0; k < n; k++) srcq[s].push_back(word(s, base + k));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] exp, input int max);
    for (int c = 0; c < max; c++) begin
      if (grant == exp) break;
      tick();
    end
    check(name, grant, exp);
  endtask

  task automatic wait_drain(input string name, input int max);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max; c++) begin
      done = (grant == '0);
      for (int i = 0; i < N; i++) if (srcq[i].size() != 0) done = 1'b0;
      if (done) break;
      tick();
    end
    check(name, done, 1'b1);
  endtask

  task automatic check_bursts(input string name);
    check({name, "_count"}, bsrc.size(), es.size());
    for (int k = 0; k < es.size() && k < bsrc.size(); k++) begin
      check($sformatf("%s_src%0d", name, k), bsrc[k], es[k]);
      check($sformatf("%s_len%0d", name, k), blen[k], el[k]);
    end
  endtask

  task automatic clear_logs();
    got.delete();
    bsrc.delete();
    blen.delete();
    err_seen = 0;
  endtask

  // Reference model and per-cycle compare: evaluate at negedge, commit after posedge.
  initial begin
    logic [N-1:0]  exp_grant, exp_rd, pop, elig;
    logic          exp_empty;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  prev_grant;
    int            n_g, n_cnt, n_rr, pick;
    bit            n_err, e, acc, rel;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      exp_grant = '0; exp_rd = '0; exp_empty = 1'b1; exp_data = '0; pop = '0;
      n_g = m_g; n_cnt = m_cnt; n_rr = m_rr; n_err = 1'b0;
      if (!rst_n) begin
        n_g = -1; n_cnt = 0; n_rr = N - 1;
        check("rst_read_err", read_err, 1'b0);
      end else begin
        for (int i = 0; i < N; i++) elig[i] = src_enable[i] && (srcq[i].size() != 0);
        if (m_g >= 0) begin
          e = (srcq[m_g].size() == 0);
          exp_grant = N'(1) << m_g;
          exp_empty = e;
          exp_data  = e ? '0 : srcq[m_g][0];
          acc = out_read && !e;
          if (acc) begin
            exp_rd = N'(1) << m_g;
            pop    = exp_rd;
            got.push_back(srcq[m_g][0]);
          end
          n_cnt = m_cnt + int'(acc);
          rel = (acc && m_cnt == MB - 1) || e || !src_enable[m_g] || (preempt && m_g != 0);
          if (rel) begin n_g = -1; n_cnt = 0; end
        end else begin
          pick = -1;
          if (preempt && elig[0]) pick = 0;
          else for (int k = 1; k <= N; k++)
            if (pick < 0 && elig[(m_rr + k) % N]) pick = (m_rr + k) % N;
          if (pick >= 0) begin n_g = pick; n_rr = pick; n_cnt = 0; end
        end
        n_err = out_read && exp_empty;
        check("read_err", read_err, m_err);
      end
      check("grant", grant, exp_grant);
      check("out_empty", out_empty, exp_empty);
      check("out_data", out_data, exp_data);
      check("src_read", src_read, exp_rd);
      if (read_err) err_seen++;
      if (grant != '0 && grant != prev_grant) begin
        for (int i = 0; i < N; i++) if (grant[i]) bsrc.push_back(i);
        blen.push_back(0);
      end
      if (src_read != '0 && blen.size() > 0) blen[blen.size()-1]++;
      prev_grant = grant;
      @(posedge clk);
      #1;
      m_g = n_g; m_cnt = n_cnt; m_rr = n_rr; m_err = n_err;
      for (int i = 0; i < N; i++) if (pop[i]) void'(srcq[i].pop_front());
      #2;
      refresh();
    end
  end

  initial begin
    rst_n = 1'b0; preempt = 1'b0; rd_en = 1'b0; force_rd = 1'b0;
    src_enable = '1;
    refresh();
    #1;
    check("reset_grant", grant, '0);
    check("reset_out_empty", out_empty, 1'b1);
    check("reset_src_read", src_read, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single source, three words
    clear_logs();
    rd_en = 1'b1;
    push(2, 3, 0);
    tick();
    check("t1_grant_c1", grant, 5'b00100);
    wait_drain("t1_drain", 20);
    check("t1_words", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) check("t1_word", got[k], word(2, k));
    check("t1_no_read_err", err_seen, 0);
    es = '{2}; el = '{3};
    check_bursts("t1_burst");

    // Two sources, 40 words each, round-robin bursts of 16
    do_reset();
    tick();
    clear_logs();
    push(1, 40, 0);
    push(3, 40, 0);
    wait_drain("t2_drain", 200);
    es = '{1, 3, 1, 3, 1, 3}; el = '{16, 16, 16, 16, 8, 8};
    check_bursts("t2_burst");
    check("t2_words", got.size(), 80);
    begin
      int ctr[N];
      int w;
      for (int i = 0; i < N; i++) ctr[i] = 0;
      w = 0;
      for (int b = 0; b < es.size(); b++)
        for (int k = 0; k < el[b]; k++) begin
          if (w < got.size()) check("t2_order", got[w], word(es[b], ctr[es[b]]));
          ctr[es[b]]++;
          w++;
        end
    end
    check("t2_no_read_err", err_seen, 0);

    // TLU preemption after the fifth word of a source-1 burst
    tick();
    clear_logs();
    push(1, 30, 0);
    for (int c = 0; c < 50; c++) begin
      if (got.size() >= 4) break;
      tick();
    end
    check("t3_four_words", got.size(), 4);
    preempt = 1'b1;
    push(0, 3, 100);
    tick();
    check("t3_released", grant, '0);
    wait_grant("t3_preempt_grant", 5'b00001, 5);
    preempt = 1'b0;
    wait_drain("t3_drain", 100);
    es = '{1, 0, 1, 1}; el = '{5, 3, 16, 9};
    check_bursts("t3_burst");
    if (got.size() > 5) check("t3_first_tlu_word", got[5], word(0, 100));
    if (got.size() > 8) check("t3_resume_word", got[8], word(1, 5));

    // Read strobe while everything is empty
    tick();
    rd_en = 1'b0;
    force_rd = 1'b1;
    tick();
    force_rd = 1'b0;
    check("t4_read_err_high", read_err, 1'b1);
    check("t4_src_read_zero", src_read, '0);
    tick();
    check("t4_read_err_low", read_err, 1'b0);

    // Disable the granted source while it still holds data
    clear_logs();
    push(4, 5, 0);
    wait_grant("t5_grant4", 5'b10000, 5);
    src_enable[4] = 1'b0;
    tick();
    check("t5_released", grant, '0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t5_not_regranted", grant, '0);
    end
    check("t5_words_kept", srcq[4].size(), 5);
    src_enable = '1;
    rd_en = 1'b1;
    wait_grant("t5_regrant", 5'b10000, 5);
    wait_drain("t5_drain", 30);

    // Asynchronous reset in the middle of a burst
    tick();
    clear_logs();
    push(2, 10, 0);
    wait_grant("t6_grant2", 5'b00100, 5);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", grant, '0);
    check("t6_rst_out_empty", out_empty, 1'b1);
    check("t6_rst_out_data", out_data, '0);
    check("t6_rst_src_read", src_read, '0);
    tick();
    push(3, 5, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_restart_from_0", grant, 5'b00100);
    wait_drain("t6_drain", 60);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
